// File: rtl/conbus_pack.sv
// -----------------------------------------------------------------------------
// conbus_pack
//   Shared definitions for the conbus Wishbone interconnect and its slaves.
//
//   dw                  : data bus width in bits
//   aw                  : address bus width in bits
//   wb_slave_state_t    : state encoding of the wb_slave_regfile FSM
//   WB_WAIT_CNT_W       : width of the slave wait-state counter (0..15)
//   wb_addr_ok()        : true when a byte address is word aligned and falls
//                         inside a register file of the given depth
// -----------------------------------------------------------------------------
package conbus_pack;

  localparam int dw = 32;
  localparam int aw = 32;

  localparam int WB_WAIT_CNT_W = 4;

  // WBS_RTY is only reachable when the retry feature is built in; in the
  // default build it is an unused encoding.
  typedef enum logic [2:0] {
    WBS_IDLE = 3'd0,
    WBS_WAIT = 3'd1,
    WBS_ACK  = 3'd2,
    WBS_ERR  = 3'd3,
    WBS_RTY  = 3'd4
  } wb_slave_state_t;

  // The address is passed one bit wider than the bus so that a burst's
  // "next address" (adr + 4) cannot wrap around into range.
  function automatic logic wb_addr_ok(input logic [aw:0] a,
                                      input int unsigned depth);
    logic [aw:0] lim;
    lim = (aw+1)'(depth) << 2;
    return (a[1:0] == 2'b00) && (a < lim);
  endfunction

endpackage : conbus_pack

// File: rtl/wb_slave_regfile.sv
// -----------------------------------------------------------------------------
// wb_slave_regfile
//   Wishbone slave holding DEPTH dw-bit registers with byte-lane writes,
//   programmable wait states before the first ack of a cycle, zero-wait
//   consecutive-address (cab) bursts, and error termination on out-of-range
//   or misaligned addresses.
//
//   Optional feature (compile-time macro WB_SLAVE_RTY_EN):
//     defined   -> port busy exists; a request seen in IDLE with busy=1 is
//                  terminated with a single-cycle rty and no write.
//     undefined -> no busy port, rty is tied low.
//
//   Parameters
//     DEPTH        number of registers, power of two, 2..256
//     WAIT_STATES  idle cycles before the first ack of a cycle, 0..15
//
//   Ports
//     clk     in   rising-edge clock
//     rst     in   asynchronous active-low reset
//     adr     in   byte address; word index adr[$clog2(DEPTH)+1:2]
//     sel     in   byte enables
//     dat_i   in   write data
//     dat_o   out  read data (zero unless a read is being acked)
//     we      in   write enable
//     cab     in   consecutive-address burst
//     cyc     in   bus cycle valid
//     stb     in   strobe (already slave-select gated)
//     ack     out  normal termination
//     err     out  error termination
//     rty     out  retry termination
//     busy    in   (WB_SLAVE_RTY_EN only) request a retry
//
//   Handshake: a request is cyc & stb high at a rising edge. The slave answers
//   with exactly one of ack/err/rty, each driven from FSM state and qualified
//   by cyc, so a termination never appears in a cycle where cyc is low. A
//   write commits at the rising edge where ack=1 and we=1. The master keeps
//   its request stable until it sees a termination; in a cab burst it moves
//   to the next word after each ack and drops cab on its final beat.
// -----------------------------------------------------------------------------
module wb_slave_regfile
  import conbus_pack::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [aw-1:0]     adr,
  input  logic [dw/8-1:0]   sel,
  input  logic [dw-1:0]     dat_i,
  output logic [dw-1:0]     dat_o,
  input  logic              we,
  input  logic              cab,
  input  logic              cyc,
  input  logic              stb,
  output logic              ack,
  output logic              err,
  output logic              rty
`ifdef WB_SLAVE_RTY_EN
  ,
  input  logic              busy
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  // Value loaded on entry to WAIT. WAIT is skipped entirely when
  // WAIT_STATES is 0, so the 0 case only needs to be a legal constant.
  localparam logic [WB_WAIT_CNT_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WB_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_slave_state_t            r_state;
  wb_slave_state_t            w_state_nxt;
  logic [WB_WAIT_CNT_W-1:0]   r_wait_cnt;
  logic [WB_WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
  logic [dw-1:0]              r_regs [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             w_req;
  logic             w_busy;
  logic [aw:0]      w_adr_ext;
  logic [aw:0]      w_adr_next;
  logic             w_adr_ok;
  logic             w_next_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr;

  assign w_req      = cyc & stb;
  assign w_adr_ext  = {1'b0, adr};
  assign w_adr_next = w_adr_ext + (aw+1)'(4);
  assign w_adr_ok   = wb_addr_ok(w_adr_ext, DEPTH);
  // In a burst the master is still presenting the beat being acked, so the
  // beat that would follow lives at adr + 4.
  assign w_next_ok  = wb_addr_ok(w_adr_next, DEPTH);
  assign w_idx      = adr[IDX_W+1:2];

`ifdef WB_SLAVE_RTY_EN
  assign w_busy = busy;
`else
  assign w_busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      WBS_IDLE: begin
        w_wait_cnt_nxt = '0;
        if (w_req) begin
          if (w_busy) begin
            w_state_nxt = WBS_RTY;
          end else if (!w_adr_ok) begin
            w_state_nxt = WBS_ERR;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = WBS_WAIT;
            w_wait_cnt_nxt = WS_LOAD;
          end else begin
            w_state_nxt = WBS_ACK;
          end
        end
      end
      WBS_WAIT: begin
        // A master that withdraws its request abandons the cycle outright.
        if (!w_req) begin
          w_state_nxt    = WBS_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt = WBS_ACK;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        end
      end
      WBS_ACK: begin
        // Staying in ACK is what produces back-to-back acks in a burst.
        if (w_req && cab) begin
          w_state_nxt = w_next_ok ? WBS_ACK : WBS_ERR;
        end else begin
          w_state_nxt = WBS_IDLE;
        end
      end
      WBS_ERR: begin
        w_state_nxt = WBS_IDLE;
      end
      WBS_RTY: begin
        w_state_nxt = WBS_IDLE;
      end
      default: begin
        w_state_nxt    = WBS_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= WBS_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Terminations: one-hot by construction since each comes from its own
  // state; gating with cyc keeps them off if the master drops the cycle.
  // ---------------------------------------------------------------------------
  assign ack = (r_state == WBS_ACK) & cyc;
  assign err = (r_state == WBS_ERR) & cyc;
`ifdef WB_SLAVE_RTY_EN
  assign rty = (r_state == WBS_RTY) & cyc;
`else
  assign rty = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  assign w_wr = ack & we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      for (int b = 0; b < dw/8; b++) begin
        if (sel[b]) begin
          r_regs[w_idx][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end
  end

  // Read data is only presented while a read is being acked so that an
  // idle slave contributes zeros to an OR-style return bus.
  assign dat_o = (ack && !we) ? r_regs[w_idx] : '0;

endmodule : wb_slave_regfile

// File: tb/tb_wb_slave_regfile.sv
module tb_wb_slave_regfile;
  import conbus_pack::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic [aw-1:0]     adr;
  logic [dw/8-1:0]   sel;
  logic [dw-1:0]     dat_i;
  logic [dw-1:0]     dat_o;
  logic              we;
  logic              cab;
  logic              cyc;
  logic              stb;
  logic              ack;
  logic              err;
  logic              rty;
`ifdef WB_SLAVE_RTY_EN
  logic              busy = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_slave_regfile #(.DEPTH(16), .WAIT_STATES(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .adr   (adr),
    .sel   (sel),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .we    (we),
    .cab   (cab),
    .cyc   (cyc),
    .stb   (stb),
    .ack   (ack),
    .err   (err),
    .rty   (rty)
`ifdef WB_SLAVE_RTY_EN
    ,
    .busy  (busy)
`endif
  );

  // ---------------------------------------------------------------------------
  // Driver: one single (non-burst) transfer. lat is the number of rising
  // edges from the request edge (counted as 1) to the first sample showing a
  // termination; 0 means none appeared within the budget.
  // ---------------------------------------------------------------------------
  task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output int lat, output logic [31:0] rd,
                          output logic t_ack, output logic t_err, output logic t_rty);
    @(negedge clk);
    adr = a; we = w; sel = s; dat_i = d; cab = 1'b0; cyc = 1'b1; stb = 1'b1;
    lat = 0; rd = '0; t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack || err || rty) begin
        lat = i; rd = dat_o; t_ack = ack; t_err = err; t_rty = rty;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lat; logic [31:0] rd; logic ta, te, tr;
    rst = 1'b0; adr = '0; sel = '0; dat_i = '0; we = 1'b0; cab = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    n_cmp++;
    if ({ack, err, rty, dat_o} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %b/%b/%b/%h expected 0/0/0/00000000", ack, err, rty, dat_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus_xfer(32'h8, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(ta === 1'b1 && lat == 2 && rd === 32'h0)) begin
      n_bad++; $display("FAIL reset_regs: ack=%b lat=%0d data=%h expected ack=1 lat=2 data=00000000", ta, lat, rd);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic ta, te, tr;
    bus_xfer(32'h8, 1'b1, 4'hF, 32'hDEADBEEF, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(ta === 1'b1 && lat == 2)) begin
      n_bad++; $display("FAIL wr_latency: ack=%b lat=%0d expected ack=1 lat=2", ta, lat);
    end
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++; $display("FAIL wr_dat_o_zero: got %h expected 00000000", rd);
    end
    bus_xfer(32'h8, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(ta === 1'b1 && lat == 2 && rd === 32'hDEADBEEF)) begin
      n_bad++; $display("FAIL rd_0x8: ack=%b lat=%0d data=%h expected ack=1 lat=2 data=deadbeef", ta, lat, rd);
    end
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd; logic ta, te, tr;
    bus_xfer(32'h4, 1'b1, 4'hF, 32'h11223344, lat, rd, ta, te, tr);
    bus_xfer(32'h4, 1'b1, 4'h1, 32'h000000AA, lat, rd, ta, te, tr);
    bus_xfer(32'h4, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'h112233AA) begin
      n_bad++; $display("FAIL byte_lane0: got %h expected 112233aa", rd);
    end
    bus_xfer(32'hC, 1'b1, 4'hF, 32'h55667788, lat, rd, ta, te, tr);
    bus_xfer(32'hC, 1'b1, 4'hA, 32'hAABBCCDD, lat, rd, ta, te, tr);
    bus_xfer(32'hC, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'hAA66CC88) begin
      n_bad++; $display("FAIL byte_lanes_1_3: got %h expected aa66cc88", rd);
    end
  endtask

  task automatic test_error();
    int lat; logic [31:0] rd; logic ta, te, tr;
    bus_xfer(32'h40, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(te === 1'b1 && ta === 1'b0 && lat == 1 && rd === 32'h0)) begin
      n_bad++; $display("FAIL err_rd_0x40: err=%b ack=%b lat=%0d data=%h expected err=1 ack=0 lat=1 data=00000000", te, ta, lat, rd);
    end
    // 0x44 aliases word 1 if the range check were missing.
    bus_xfer(32'h44, 1'b1, 4'hF, 32'hFFFFFFFF, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(te === 1'b1 && ta === 1'b0)) begin
      n_bad++; $display("FAIL err_wr_0x44: err=%b ack=%b expected err=1 ack=0", te, ta);
    end
    // Misaligned address aliasing word 2.
    bus_xfer(32'h9, 1'b1, 4'hF, 32'hFFFFFFFF, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(te === 1'b1 && ta === 1'b0)) begin
      n_bad++; $display("FAIL err_wr_0x9: err=%b ack=%b expected err=1 ack=0", te, ta);
    end
    bus_xfer(32'h4, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'h112233AA) begin
      n_bad++; $display("FAIL err_no_write_0x4: got %h expected 112233aa", rd);
    end
    bus_xfer(32'h8, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL err_no_write_0x8: got %h expected deadbeef", rd);
    end
    // err lasts one cycle even if the master keeps requesting.
    @(negedge clk);
    adr = 32'h40; we = 1'b0; sel = 4'hF; cab = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL err_pulse_first: got %b expected 1", err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse_second: got %b expected 0", err);
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_burst();
    logic [31:0] bdat [4];
    int lat; int nack; logic [31:0] rd; logic ta, te, tr;
    bdat[0] = 32'hA0A0_0001; bdat[1] = 32'hB1B1_0002; bdat[2] = 32'hC2C2_0003; bdat[3] = 32'hD3D3_0004;
    @(negedge clk);
    adr = 32'h0; we = 1'b1; sel = 4'hF; cab = 1'b1; dat_i = bdat[0]; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++; $display("FAIL burst_first_ack: lat=%0d expected 2", lat);
    end
    nack = 0;
    for (int b = 0; b < 4; b++) begin
      if (ack) nack++;
      @(posedge clk); #1;
      if (b < 3) begin
        adr = 32'(4 * (b + 1)); dat_i = bdat[b+1]; cab = (b + 1 < 3);
      end
    end
    n_cmp++;
    if (nack != 4) begin
      n_bad++; $display("FAIL burst_ack_count: got %0d expected 4", nack);
    end
    n_cmp++;
    if (ack !== 1'b0) begin
      n_bad++; $display("FAIL burst_end_ack: got %b expected 0", ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus_xfer(32'(4 * b), 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
      n_cmp++;
      if (rd !== bdat[b]) begin
        n_bad++; $display("FAIL burst_readback[%0d]: got %h expected %h", b, rd, bdat[b]);
      end
    end
  endtask

  task automatic test_burst_err();
    int lat; logic [31:0] rd; logic ta, te, tr;
    @(negedge clk);
    adr = 32'h38; we = 1'b1; sel = 4'hF; cab = 1'b1; dat_i = 32'h3838_3838; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    @(posedge clk); #1;
    adr = 32'h3C; dat_i = 32'h3C3C_3C3C;
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++; $display("FAIL burst_err_beat1_ack: got %b expected 1", ack);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!(err === 1'b1 && ack === 1'b0)) begin
      n_bad++; $display("FAIL burst_err_term: err=%b ack=%b expected err=1 ack=0", err, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0;
    bus_xfer(32'h3C, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'h3C3C_3C3C) begin
      n_bad++; $display("FAIL burst_err_last_beat: got %h expected 3c3c3c3c", rd);
    end
  endtask

  task automatic test_wait_abort();
    int lat; int nack; logic [31:0] rd; logic ta, te, tr;
    @(negedge clk);
    adr = 32'h0; we = 1'b1; sel = 4'hF; cab = 1'b0; dat_i = 32'h12345678; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    cyc = 1'b0; we = 1'b0;
    n_cmp++;
    if (nack != 0) begin
      n_bad++; $display("FAIL abort_ack: got %0d acks expected 0", nack);
    end
    bus_xfer(32'h0, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'hA0A0_0001) begin
      n_bad++; $display("FAIL abort_no_write: got %h expected a0a00001", rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic ta, te, tr;
    @(negedge clk);
    adr = 32'h10; we = 1'b1; sel = 4'hF; cab = 1'b0; dat_i = 32'h0BADF00D; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++; $display("FAIL b2b_first_lat: lat=%0d expected 2", lat);
    end
    @(posedge clk); #1;
    adr = 32'h14; dat_i = 32'h600DCAFE;
    n_cmp++;
    if (ack !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gap: ack=%b expected 0", ack);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin lat = i; break; end
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++; $display("FAIL b2b_second_lat: lat=%0d expected 2", lat);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    bus_xfer(32'h10, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL b2b_rd_0x10: got %h expected 0badf00d", rd);
    end
    bus_xfer(32'h14, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (rd !== 32'h600DCAFE) begin
      n_bad++; $display("FAIL b2b_rd_0x14: got %h expected 600dcafe", rd);
    end
  endtask

`ifdef WB_SLAVE_RTY_EN
  task automatic test_retry();
    int lat; logic [31:0] rd; logic ta, te, tr;
    busy = 1'b1;
    bus_xfer(32'h18, 1'b1, 4'hF, 32'h13579BDF, lat, rd, ta, te, tr);
    busy = 1'b0;
    n_cmp++;
    if (!(tr === 1'b1 && ta === 1'b0 && lat == 1)) begin
      n_bad++; $display("FAIL retry_busy: rty=%b ack=%b lat=%0d expected rty=1 ack=0 lat=1", tr, ta, lat);
    end
    bus_xfer(32'h18, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(ta === 1'b1 && lat == 2 && rd === 32'h0)) begin
      n_bad++; $display("FAIL retry_no_write: ack=%b lat=%0d data=%h expected ack=1 lat=2 data=00000000", ta, lat, rd);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    int lat; int nack; logic [31:0] rd; logic ta, te, tr;
    @(negedge clk);
    adr = 32'h0; we = 1'b1; sel = 4'hF; cab = 1'b0; dat_i = 32'hCAFEF00D; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ack, err, rty, dat_o} !== '0) begin
      n_bad++; $display("FAIL rst_mid_wait_outputs: got %b/%b/%b/%h expected 0/0/0/00000000", ack, err, rty, dat_o);
    end
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    n_cmp++;
    if (nack != 0) begin
      n_bad++; $display("FAIL rst_mid_wait_ack: got %0d acks expected 0", nack);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b1;
    bus_xfer(32'h0, 1'b0, 4'hF, 32'h0, lat, rd, ta, te, tr);
    n_cmp++;
    if (!(ta === 1'b1 && lat == 2 && rd === 32'h0)) begin
      n_bad++; $display("FAIL rst_mid_wait_after: ack=%b lat=%0d data=%h expected ack=1 lat=2 data=00000000", ta, lat, rd);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_error();
    test_burst();
    test_burst_err();
    test_wait_abort();
    test_back_to_back();
`ifdef WB_SLAVE_RTY_EN
    test_retry();
`endif
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_wb_slave_regfile

// File: doc/wb_slave_regfile.md
WB_SLAVE_REGFILE -- requirements
Module: wb_slave_regfile

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of dw-bit registers; power of two, 2..256.
REQ-002 SHALL have parameter WAIT_STATES, default 1: idle cycles inserted before the first ack of a cycle; range 0..15.
REQ-003 SHALL have ports:
- clk  input  1  single clock; all state on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- adr  input  aw  byte address; word index is adr[$clog2(DEPTH)+1:2].
- sel  input  dw/8  byte enables.
- dat_i  input  dw  write data from the interconnect.
- dat_o  output  dw  read data to the interconnect.
- we  input  1  write enable.
- cab  input  1  consecutive-address burst.
- cyc  input  1  bus cycle valid.
- stb  input  1  strobe, already slave-select gated by the interconnect.
- ack  output  1  normal termination.
- err  output  1  error termination.
- rty  output  1  retry termination.
- busy  input  1  present only with WB_SLAVE_RTY_EN; requests retry.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, ACK, ERR.
REQ-005 SHALL treat a request as cyc & stb high at a rising edge.
REQ-006 IDLE: request with out-of-range address (adr above DEPTH*4-1, or adr[1:0] nonzero) -> ERR; otherwise -> WAIT if WAIT_STATES>0, else ACK.
REQ-007 WAIT SHALL load a counter with WAIT_STATES-1 on entry, decrement every cycle, go to ACK when it reaches 0; ack asserts exactly WAIT_STATES+1 cycles after the request edge.
REQ-008 WAIT: cyc or stb low at any edge -> IDLE, no ack, no write.
REQ-009 ACK SHALL drive ack=1 for one cycle, then go to IDLE, unless cab & cyc & stb are high at that edge with an in-range next address, in which case ack stays 1 (zero-wait burst beat).
REQ-010 A burst beat with an out-of-range address SHALL go to ERR.
REQ-011 ERR SHALL drive err=1 for exactly one cycle, then go to IDLE; no register is modified.
REQ-012 Writes SHALL commit at the rising edge where ack=1 and we=1, per byte lane where sel bit is 1; other lanes unchanged.
REQ-013 dat_o SHALL be the combinational read of the register at the current word index while ack=1 and we=0, and all zeros otherwise.
REQ-014 ack, err and rty SHALL be registered, mutually exclusive, and never asserted while cyc=0 in the same cycle.
REQ-015 A new request in the cycle after a non-burst ack SHALL be processed from IDLE with full wait states.

Reset
REQ-016 rst low SHALL asynchronously force state IDLE, counter 0, ack=err=rty=0, dat_o=0, and all registers 0.
REQ-017 Reset asserted mid-WAIT or mid-burst SHALL abort with no further ack and no partial write beyond beats already acked.

Configuration
REQ-018 With WB_SLAVE_RTY_EN defined: busy port present; a request sampled in IDLE with busy=1 SHALL drive rty=1 for exactly one cycle, then IDLE, with no write.
REQ-019 Without WB_SLAVE_RTY_EN: busy port absent, rty tied 0.

Structure
REQ-020 dw and aw SHALL come from conbus_pack; the FSM state enum wb_slave_state_t SHALL be added to conbus_pack.
REQ-021 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-022 WAIT_STATES=1: write 0xDEADBEEF to adr 0x8, sel=0xF -> ack high exactly 2 cycles after request; a later read of 0x8 returns 0xDEADBEEF with ack.
REQ-023 Byte write 0x000000AA to 0x4, sel=0x1, over register 0x11223344 -> read 0x4 returns 0x112233AA.
REQ-024 DEPTH=16: read adr 0x40 -> err=1 for one cycle, ack=0, dat_o=0; register contents unchanged.
REQ-025 cab burst: write 4 beats to 0x0, 0x4, 0x8, 0xC -> first ack after WAIT_STATES+1 cycles, then ack continuous for 4 cycles; read back matches.
REQ-026 rst pulled low during WAIT -> ack never asserts, all outputs 0 immediately; next request after reset acks normally.
REQ-027 With WB_SLAVE_RTY_EN: request with busy=1 -> rty one cycle, ack=0; retry with busy=0 -> ack.
